// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART loopback path: the mode encodings driven
// on the uart_loop_fifo mode port and the send-side FSM state type.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transform applied to each word as it leaves the FIFO.
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,  // d
        MODE_INV  = 2'b01,  // ~d
        MODE_INC  = 2'b10,  // d + 1, wrapping
        MODE_DROP = 2'b11   // word is consumed and discarded
    } mode_t;

    // Send FSM: IDLE has no word presented, HOLD presents data_send.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } send_state_t;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead output (dout is the head entry whenever
// empty is low). Pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
//
// Ports
//   clk    : clock, rising edge
//   rstn   : asynchronous active-low reset (pointers only)
//   push   : write din this edge; ignored when full unless pop also occurs
//   pop    : consume the head entry this edge; ignored when empty
//   din    : write data
//   dout   : head entry
//   full   : DEPTH entries stored
//   empty  : no entries stored
//   level  : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_en;
    logic             push_en;

    // Same index with different wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves at the same edge.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Modular pointer difference is the occupancy; it cannot exceed DEPTH.
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; empty is derived from the pointers, so stale
    // contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule : sync_fifo

// File: rtl/uart_loop_fifo.sv
// ---------------------------------------------------------------------------
// uart_loop_fifo
// Receive-to-send loopback: received words are queued in a FIFO, transformed
// on the way out and presented to the sender with a valid/ready hold. Words
// arriving at a full FIFO are dropped and counted.
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset (deassertion pre-synchronised)
//   valid_rec  : one-cycle strobe, data_rec valid
//   data_rec   : received word
//   mode       : 00 pass, 01 invert, 10 increment, 11 discard
//   clr_ovf    : clears ovf and ovf_cnt; wins over a drop at the same edge
//   ready_send : sender accepts data_send at an edge where valid_send is high
//   valid_send : data_send holds a word for the sender
//   data_send  : word to transmit
//   level      : FIFO occupancy
//   ovf        : sticky, at least one word dropped
//   ovf_cnt    : dropped-word count, saturating
// ---------------------------------------------------------------------------
module uart_loop_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_rec,
    input  logic [WIDTH-1:0]         data_rec,
    input  logic [1:0]               mode,
    input  logic                     clr_ovf,
    input  logic                     ready_send,
    output logic                     valid_send,
    output logic [WIDTH-1:0]         data_send,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNTW-1:0]          ovf_cnt
);

    send_state_t      state;
    send_state_t      state_nxt;
    mode_t            mode_sel;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             pop;
    logic             keep;
    logic             drop;
    logic [WIDTH-1:0] xform;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (valid_rec),
        .pop   (pop),
        .din   (data_rec),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign mode_sel = mode_t'(mode);

    // Pop whenever the output slot is free now or frees at this edge.
    assign pop  = !fifo_empty && ((state == IDLE) || ready_send);
    assign keep = (mode_sel != MODE_DROP);
    assign drop = valid_rec && fifo_full && !pop;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        xform = fifo_dout;
        case (mode_sel)
            MODE_INV: xform = ~fifo_dout;
            MODE_INC: xform = fifo_dout + WIDTH'(1);
            default:  xform = fifo_dout;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. A discarded word in HOLD still completes the current
    // transfer, leaving nothing to present, so the FSM falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop && keep) state_nxt = HOLD;
            HOLD: if (ready_send)  state_nxt = (pop && keep) ? HOLD : IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        valid_send = (state == HOLD);
    end

    // The held word only changes on a pop that keeps it, which in HOLD can
    // happen only with ready_send high, so data_send is stable while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)             data_send <= '0;
        else if (pop && keep)  data_send <= xform;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (clr_ovf) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNTW'(1);
        end
    end

endmodule : uart_loop_fifo

// File: doc/uart_loop_fifo.md
UART_LOOP_FIFO -- requirements
Module: uart_loop_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter CNTW, default 16, overflow counter width.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid_rec  input  1  one-cycle pulse from the receiver; data_rec is valid.
REQ-007 SHALL have port data_rec  input  WIDTH  received word.
REQ-008 SHALL have port mode  input  2  transform select: 00 pass, 01 bitwise invert, 10 increment, 11 discard.
REQ-009 SHALL have port clr_ovf  input  1  clears the overflow flag and the overflow counter.
REQ-010 SHALL have port ready_send  input  1  sender is idle and able to accept a word.
REQ-011 SHALL have port valid_send  output  1  data_send holds a word for the sender.
REQ-012 SHALL have port data_send  output  WIDTH  word to transmit.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port ovf  output  1  sticky flag: at least one word dropped.
REQ-015 SHALL have port ovf_cnt  output  CNTW  count of dropped words; saturates at all-ones.

Function
REQ-016 SHALL write data_rec into the FIFO at the rising edge where valid_rec=1, provided the FIFO is not full, or is full and a pop occurs at the same edge.
REQ-017 SHALL, when valid_rec=1 at a full FIFO with no pop at that edge, drop the word, set ovf, and increment ovf_cnt (saturating).
REQ-018 SHALL give clr_ovf priority over a simultaneous drop: the flag and counter read 0 after that edge.
REQ-019 SHALL implement the send FSM with states IDLE, HOLD.
REQ-020 IDLE: when the FIFO is non-empty, SHALL pop one word at the next edge and apply the mode transform as sampled at the pop edge.
REQ-021 IDLE, modes 00/01/10: SHALL load data_send and move to HOLD with valid_send=1.
REQ-022 IDLE, mode 11: SHALL discard the word and stay in IDLE.
REQ-023 HOLD: SHALL keep valid_send=1 with data_send stable until an edge where ready_send=1.
REQ-024 HOLD, at that edge: SHALL complete the transfer, then pop again if the FIFO is non-empty (staying in HOLD with the new word) or go to IDLE with valid_send=0.
REQ-025 Transforms: SHALL use 00 = d, 01 = ~d, 10 = d+1 mod 2^WIDTH (all-ones wraps to 0).
REQ-026 Latency: SHALL set valid_send high 2 edges after valid_rec is sampled into an empty FIFO in IDLE: edge 1 writes, edge 2 pops and loads.
REQ-027 Write and read pointers SHALL each be $clog2(DEPTH)+1 bits; full and empty SHALL be decoded from the MSB/LSB comparison; pointers wrap without special-casing.
REQ-028 level SHALL update at every edge as +1, -1, or unchanged on simultaneous push and pop, and never exceed DEPTH.
REQ-029 A push into an empty FIFO SHALL NOT bypass to data_send in the same cycle.

Reset
REQ-030 While rstn=0: FSM = IDLE, valid_send=0, data_send=0, pointers=0, level=0, ovf=0, ovf_cnt=0.
REQ-031 Assertion mid-operation SHALL abort any held word and discard FIFO contents; no partial transfer may survive.
REQ-032 Deassertion SHALL be synchronised externally; the block needs no internal reset synchroniser.

Structure
REQ-033 A shared package uart_pkg SHALL hold the mode encodings (MODE_PASS, MODE_INV, MODE_INC, MODE_DROP) and the FSM state enum.
REQ-034 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level).
REQ-035 The FSM, transform and overflow logic SHALL reside in uart_loop_fifo.

Verification
REQ-036 Bench SHALL cover: reset; valid_rec with data_rec=0x41, mode 00, ready_send=1 -> valid_send=1 and data_send=0x41 exactly 2 edges later, for 1 cycle.
REQ-037 Bench SHALL cover: modes 01 and 10 with input 0xFF -> data_send 0x00 in both modes (wrap on increment).
REQ-038 Bench SHALL cover: ready_send=0, 20 pulses with DEPTH=16 -> level=16, one word held in HOLD, ovf=1, ovf_cnt=3; after release, 17 words leave in order.
REQ-039 Bench SHALL cover: full FIFO, valid_rec coincident with a HOLD pop edge -> word accepted, ovf_cnt unchanged.
REQ-040 Bench SHALL cover: mode 11 with 5 words queued -> level reaches 0, valid_send stays 0 throughout.
REQ-041 Bench SHALL cover: rstn pulled low during HOLD with level=4 -> valid_send=0 and level=0 immediately; no word emitted after release.
